// File: rtl/uart_rx_fifo_if.sv
// Receive-side handshake between the UART receiver FIFO and its consumer.
// The FIFO side uses the master modport; the consumer uses slave.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          rx_ready_i;
  logic          rx_valid_o;
  logic [7:0]    rx_data_o;
  logic          rx_ferr_o;
  logic          rx_perr_o;
  logic [LW-1:0] level_o;

  modport master (
    input  rx_ready_i,
    output rx_valid_o, rx_data_o, rx_ferr_o, rx_perr_o, level_o
  );

  modport slave (
    output rx_ready_i,
    input  rx_valid_o, rx_data_o, rx_ferr_o, rx_perr_o, level_o
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (configurable bit time, width, parity, stop bits) feeding a
// show-ahead FIFO whose entries carry framing and parity error flags.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             rx_i,
  input  logic             clr_i,
  output logic             overrun_o,
  uart_rx_fifo_if.master   rx_if
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_PUSH, S_BREAK
  } state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, sync2_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  overrun_q, overrun_d;
  logic [EW-1:0]         mem_q [FIFO_DEPTH];

  logic                  rxs;
  logic                  sample;
  logic                  push_en, pop_en, wr_en, full, empty;
  logic [EW-1:0]         head;

  assign rxs    = sync2_q;
  assign sample = (cnt_q == '0);

  // State register and all datapath flops
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= rx_i;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {ferr_q, perr_q, shift_q};
    end
  end

  // Next-state and frame assembly
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = HALF_CNT;
        end
      end
      S_START: begin
        if (!sample) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rxs) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DATA;
          cnt_d   = FULL_CNT;
          bit_d   = 3'(DATA_BITS - 1);
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_DATA: begin
        if (!sample) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          cnt_d   = FULL_CNT;
          if (bit_q != 3'd0) begin
            bit_d = bit_q - 3'd1;
          end else if (PARITY != 0) begin
            state_d = S_PARITY;
          end else begin
            state_d = S_STOP;
            bit_d   = 3'(STOP_BITS - 1);
          end
        end
      end
      S_PARITY: begin
        if (!sample) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Odd parity flags an even total of ones, even parity an odd total
          perr_d  = (PARITY == 1) ? ~(^shift_q ^ rxs) : (^shift_q ^ rxs);
          state_d = S_STOP;
          cnt_d   = FULL_CNT;
          bit_d   = 3'(STOP_BITS - 1);
        end
      end
      S_STOP: begin
        if (!sample) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          if (!rxs) ferr_d = 1'b1;
          cnt_d = FULL_CNT;
          if (bit_q != 3'd0) begin
            bit_d = bit_q - 3'd1;
          end else begin
            state_d = S_PUSH;
          end
        end
      end
      S_PUSH: begin
        // A clean frame lets the next start bit be caught in this same cycle
        if (ferr_q) begin
          state_d = S_BREAK;
        end else if (!rxs) begin
          state_d = S_START;
          cnt_d   = HALF_CNT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BREAK: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: FIFO control, overrun flag and show-ahead head entry
  always_comb begin
    push_en   = (state_q == S_PUSH);
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_en    = !empty && rx_if.rx_ready_i;
    wr_en     = push_en && (!full || pop_en);
    wr_ptr_d  = wr_en  ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overrun_d = overrun_q;
    if (clr_i) overrun_d = 1'b0;
    if (push_en && full && !pop_en) overrun_d = 1'b1;

    head                = mem_q[rd_ptr_q[AW-1:0]];
    rx_if.rx_valid_o    = !empty;
    rx_if.rx_data_o     = '0;
    rx_if.rx_ferr_o     = 1'b0;
    rx_if.rx_perr_o     = 1'b0;
    if (!empty) begin
      rx_if.rx_data_o[DATA_BITS-1:0] = head[DATA_BITS-1:0];
      rx_if.rx_ferr_o                = head[EW-1];
      rx_if.rx_perr_o                = head[EW-2];
    end
    rx_if.level_o = wr_ptr_q - rd_ptr_q;
    overrun_o     = overrun_q;
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboarded bench: an 8N1 receiver (a) and a 7E2 receiver (b), both with
// a 4-entry FIFO, driven by serial frames built in the bench.
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic clr_a = 1'b0, clr_b = 1'b0;
  logic ovr_a, ovr_b;

  uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) if_a ();
  uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) if_b ();

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                 .FIFO_DEPTH(DEPTH)) u_dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .rx_i(rx_a), .clr_i(clr_a),
    .overrun_o(ovr_a), .rx_if(if_a));

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
                 .FIFO_DEPTH(DEPTH)) u_dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .rx_i(rx_b), .clr_i(clr_b),
    .overrun_o(ovr_b), .rx_if(if_b));

  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] sb_a[$];
  logic [9:0] sb_b[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx_a = v; else rx_b = v;
  endtask

  task automatic set_ready(input int sel, input logic v);
    if (sel == 0) if_a.rx_ready_i = v; else if_b.rx_ready_i = v;
  endtask

  function automatic logic [9:0] head(input int sel);
    if (sel == 0) return {if_a.rx_ferr_o, if_a.rx_perr_o, if_a.rx_data_o};
    return {if_b.rx_ferr_o, if_b.rx_perr_o, if_b.rx_data_o};
  endfunction

  function automatic logic [31:0] level(input int sel);
    if (sel == 0) return 32'(if_a.level_o);
    return 32'(if_b.level_o);
  endfunction

  function automatic logic valid(input int sel);
    return (sel == 0) ? if_a.rx_valid_o : if_b.rx_valid_o;
  endfunction

  task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_line(sel, bits[i]);
      repeat (CPB) tick();
    end
    set_line(sel, 1'b1);
  endtask

  task automatic send_a(input logic [7:0] d);
    send_bits(0, {6'b0, 1'b1, d, 1'b0}, 10);
  endtask

  // Even parity bit makes the count of ones over data+parity even
  task automatic send_b(input logic [6:0] d, input logic flip);
    logic p;
    p = (^d) ^ flip;
    send_bits(1, {5'b0, 2'b11, p, d, 1'b0}, 11);
  endtask

  task automatic pop_check(input int sel, input string tag);
    logic [9:0] exp;
    exp = 10'h3ff;
    if (sel == 0 && sb_a.size() > 0) exp = sb_a.pop_front();
    if (sel == 1 && sb_b.size() > 0) exp = sb_b.pop_front();
    check({tag, "_valid"}, 32'(valid(sel)), 32'd1);
    check(tag, 32'(head(sel)), 32'(exp));
    $display("txn %s: data=0x%02h ferr=%0b perr=%0b level=%0d", tag,
             head(sel)[7:0], head(sel)[9], head(sel)[8], level(sel));
    set_ready(sel, 1'b1);
    tick();
    set_ready(sel, 1'b0);
  endtask

  initial begin
    if_a.rx_ready_i = 1'b0;
    if_b.rx_ready_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_valid", 32'(valid(0)), 32'd0);
    check("rst_level", level(0), 32'd0);
    check("rst_head", 32'(head(0)), 32'd0);
    check("rst_ovr", 32'(ovr_a), 32'd0);
    check("rst_valid_b", 32'(valid(1)), 32'd0);

    // ready on an empty FIFO must be ignored
    set_ready(0, 1'b1);
    repeat (3) tick();
    set_ready(0, 1'b0);
    check("empty_ready_level", level(0), 32'd0);

    // Basic 8N1
    sb_a.push_back({2'b00, 8'h41}); send_a(8'h41);
    sb_a.push_back({2'b00, 8'hA4}); send_a(8'hA4);
    check("basic_level2", level(0), 32'd2);
    pop_check(0, "basic_0x41");
    check("basic_level1", level(0), 32'd1);
    pop_check(0, "basic_0xA4");
    check("basic_level0", level(0), 32'd0);

    // 7E2: good then flipped parity
    sb_b.push_back({2'b00, 8'h35}); send_b(7'h35, 1'b0);
    sb_b.push_back({2'b01, 8'h35}); send_b(7'h35, 1'b1);
    check("par_level", level(1), 32'd2);
    pop_check(1, "par_ok");
    pop_check(1, "par_bad");

    // Break: three frame times low gives one framing-error entry
    set_line(0, 1'b0);
    repeat (3 * 10 * CPB) tick();
    set_line(0, 1'b1);
    repeat (20) tick();
    sb_a.push_back({2'b10, 8'h00});
    check("break_level", level(0), 32'd1);
    pop_check(0, "break_entry");
    sb_a.push_back({2'b00, 8'h55}); send_a(8'h55);
    pop_check(0, "after_break_0x55");

    // Glitch: short low pulse must not push
    set_line(0, 1'b0);
    repeat (4) tick();
    set_line(0, 1'b1);
    repeat (30) tick();
    check("glitch_level", level(0), 32'd0);
    check("glitch_valid", 32'(valid(0)), 32'd0);
    sb_a.push_back({2'b00, 8'h3C}); send_a(8'h3C);
    pop_check(0, "after_glitch_0x3C");

    // Overrun: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) begin
      if (sb_a.size() < DEPTH) sb_a.push_back({2'b00, 8'(i)});
      send_a(8'(i));
    end
    check("ovr_level", level(0), 32'd4);
    check("ovr_set", 32'(ovr_a), 32'd1);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    check("ovr_clr", 32'(ovr_a), 32'd0);
    for (int i = 1; i <= 4; i++) pop_check(0, "ovr_entry");

    // Refill, then pop exactly on the push edge of the next frame
    for (int i = 0; i < 4; i++) begin
      sb_a.push_back({2'b00, 8'(8'h11 + i)});
      send_a(8'(8'h11 + i));
    end
    check("refill_level", level(0), 32'd4);
    sb_a.push_back({2'b00, 8'h15});
    fork
      send_a(8'h15);
      begin
        // start sampled 3 edges after the line drops, stop sample 152 later, push 1 after
        repeat (155) tick();
        check("pushpop_head", 32'(head(0)), 32'(sb_a.pop_front()));
        set_ready(0, 1'b1);
        tick();
        set_ready(0, 1'b0);
        check("pushpop_level", level(0), 32'd4);
      end
    join
    check("pushpop_ovr", 32'(ovr_a), 32'd0);
    for (int i = 0; i < 4; i++) pop_check(0, "pushpop_entry");

    // Reset mid-frame with a full FIFO and overrun set
    for (int i = 0; i < 5; i++) send_a(8'(8'h60 + i));
    check("pre_rst_ovr", 32'(ovr_a), 32'd1);
    set_line(0, 1'b0);
    repeat (CPB) tick();
    for (int i = 0; i < 3; i++) begin
      set_line(0, 1'b1);
      repeat (CPB) tick();
    end
    set_line(0, 1'b0);
    repeat (CPB / 2) tick();
    rst = 1'b1;
    set_line(0, 1'b1);
    tick();
    rst = 1'b0;
    sb_a.delete();
    check("mid_rst_valid", 32'(valid(0)), 32'd0);
    check("mid_rst_level", level(0), 32'd0);
    check("mid_rst_head", 32'(head(0)), 32'd0);
    check("mid_rst_ovr", 32'(ovr_a), 32'd0);
    repeat (CPB * 12) tick();
    check("mid_rst_idle_level", level(0), 32'd0);
    sb_a.push_back({2'b00, 8'h5A}); send_a(8'h5A);
    pop_check(0, "after_rst_0x5A");
    check("final_level", level(0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised, synthesizable UART receiver with an on-chip receive FIFO, for monitoring the Ibex UART TX line (mprj_io[21]) on-chip and in simulation. It replaces the fixed 8N1, fixed-bit-time behavioural terminal with a clocked block. The block supports configurable bit time, data width, parity and stop bits. Frames are buffered in a FIFO that tags each entry with framing and parity errors, and overruns are reported.

## Interface
- CLKS_PER_BIT, 16 — clock cycles per UART bit; ≥4.
- DATA_BITS, 8 — data bits per frame; 5..8.
- PARITY, 0 — 0 none, 1 odd, 2 even.
- STOP_BITS, 1 — 1 or 2.
- FIFO_DEPTH, 16 — entries; power of two, ≥2.

Ports (name, direction, width, meaning):
- wb_clk_i  in  1  sole clock; all logic on the rising edge.
- wb_rst_i  in  1  reset; synchronous, active-high.
- rx_i  in  1  asynchronous serial input; idle high.
- rx_ready_i  in  1  consumer accepts the head entry.
- rx_valid_o  out  1  FIFO non-empty.
- rx_data_o  out  8  head data, LSB-aligned; bits above DATA_BITS are 0.
- rx_ferr_o  out  1  head entry had a framing error.
- rx_perr_o  out  1  head entry had a parity error; always 0 when PARITY=0.
- overrun_o  out  1  sticky; set when a frame is dropped because the FIFO is full.
- clr_i  in  1  clears overrun_o; does not touch the FIFO.
- level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Input sync:** rx_i passes through a 2-flop synchronizer; both flops reset to 1. All decoding uses the synchronized value rxs.
- **IDLE:** waits for rxs=0 (the level after a 1 is enough). On detection, the bit counter loads and the FSM goes to START.
- **START:** samples rxs after CLKS_PER_BIT/2 cycles (integer divide).
  - 0: go to DATA.
  - 1: glitch; return to IDLE with nothing pushed.
- **DATA:** samples every CLKS_PER_BIT cycles, DATA_BITS samples, LSB first, shifted into the assembly register.
- **PARITY** (only if PARITY≠0): one sample. perr = 1 if (XOR of data bits ^ sample) ≠ 0 for even parity, or = 0 for odd parity.
- **STOP:** STOP_BITS samples. ferr = 1 if any stop sample is 0.
- **Push:** one cycle after the last stop sample, {ferr, perr, data} is written to the FIFO.
  - If ferr=0, the FSM returns to IDLE in that same cycle.
  - If ferr=1, the FSM goes to BREAK_WAIT and stays there until rxs=1, then goes to IDLE. A break condition therefore yields exactly one entry.
- **FIFO:**
  - Show-ahead: the rx_data_o, rx_ferr_o and rx_perr_o outputs reflect the head entry whenever rx_valid_o=1.
  - Pop when rx_valid_o & rx_ready_i. rx_ready_i is ignored when the FIFO is empty.
  - Pointers are $clog2(FIFO_DEPTH)+1 bits with wrap-around. Empty when the pointers are equal; full when only the MSBs differ.
- **Full:**
  - Push while full without a same-cycle pop: the frame is dropped, FIFO contents are unchanged, and overrun_o is set.
  - Push and pop in the same cycle while full: both succeed, level is unchanged, no overrun.
- **Empty:** push and pop in the same cycle while empty is impossible, since rx_valid_o=0 at that point; the push succeeds.
- **overrun_o:** clr_i clears it. If clr_i and a new overrun occur in the same cycle, set wins.

## Timing
- Reset values: FSM=IDLE, pointers=0, level_o=0, rx_valid_o=0, rx_data_o=0, rx_ferr_o=0, rx_perr_o=0, overrun_o=0, synchronizer=1.
- Reset mid-frame: the partial frame is discarded and the FIFO is emptied. Reset has priority over every other input.
- Edge-to-detect latency: 2 cycles (synchronizer) plus 1 cycle (IDLE detect).
- Sample points: every sample is CLKS_PER_BIT cycles after the previous one; the first is CLKS_PER_BIT/2 cycles after detect.
- Push: registered one cycle after the final stop sample. rx_valid_o and level_o update on the following edge.
- Pop: level_o and the head entry update on the edge where rx_valid_o & rx_ready_i is sampled.
- Back-to-back frames: with ferr=0, the next start bit is detectable in the push cycle. No idle bit is required beyond the stop bits.

## Test plan
- **Basic 8N1:** CLKS_PER_BIT=16. Send 0x41, then 0xA4, with rx_ready_i=0. Expect level_o=2, head 0x41 with ferr=0 and perr=0. Pop once; expect head 0xA4 and level_o=1.
- **Even parity, 7 data bits, 2 stop bits:** send 0x35 with a correct parity bit, then 0x35 with the parity bit flipped. Expect entries {0x35, perr=0} then {0x35, perr=1}, upper data bit 0.
- **Framing/break:** hold rx_i low for 3 frame times, then release. Expect exactly one entry {0x00, ferr=1}. A following 0x55 frame is received cleanly.
- **Glitch:** a 4-cycle low pulse on rx_i. Expect no push, FSM back in IDLE, level_o=0.
- **Overrun and full boundary:** FIFO_DEPTH=4, send 5 frames 0x01..0x05 with no pops.
  - Expect level_o=4, overrun_o=1, contents 0x01..0x04.
  - Assert clr_i: overrun_o=0.
  - Refill to full, then pop on the exact push cycle of the next frame: no overrun, level_o stays 4.
- **Reset mid-frame:** assert wb_rst_i for 1 cycle during data bit 3 of a frame. Expect all outputs at reset values. The next full frame 0x5A is received correctly.
